// File: rtl/host_memory_bridge_if.sv
// Byte-stream and external-memory signal bundle between the host UART side,
// the bridge controller and the processor's external memory port.
interface host_memory_bridge_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        pause;
   logic        ext_mem_control;
   logic [31:0] ext_address;
   logic [31:0] ext_data;
   logic [2:0]  ext_read_mode;
   logic [2:0]  ext_write_mode;
   logic [31:0] ext_data_out;
   logic        busy;
   logic [7:0]  error_count;

   modport master (
      input  rx_data, rx_valid, tx_ready, ext_data_out,
      output rx_ready, tx_data, tx_valid, pause, ext_mem_control, ext_address,
             ext_data, ext_read_mode, ext_write_mode, busy, error_count
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, ext_data_out,
      input  rx_ready, tx_data, tx_valid, pause, ext_mem_control, ext_address,
             ext_data, ext_read_mode, ext_write_mode, busy, error_count
   );
endinterface

// File: rtl/host_memory_bridge.sv
// Host command parser that halts/runs the processor and performs word reads and
// writes through its external memory port, answering with ACK/NAK or read data.
module host_memory_bridge #(
   parameter int         PAUSE_SETTLE     = 2,
   parameter int         MEM_READ_LATENCY = 1,
   parameter int         TIMEOUT          = 100000,
   parameter bit         START_HALTED     = 1'b1,
   parameter logic [2:0] MODE_NONE        = 3'd0,
   parameter logic [2:0] MODE_WORD        = 3'd3
) (
   input logic                  clk,
   input logic                  rst,
   host_memory_bridge_if.master bus
);

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] OP_HALT  = 8'h48;
   localparam logic [7:0] OP_GO    = 8'h47;
   localparam logic [7:0] BYTE_ACK = 8'h06;
   localparam logic [7:0] BYTE_NAK = 8'h15;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_PAUSE_WAIT, S_SETUP, S_ACCESS, S_RELEASE, S_SEND
   } state_t;

   state_t      state_q, state_d;
   logic        halted_q, halted_d;
   logic        is_write_q, is_write_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [31:0] cyc_q, cyc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] resp_q, resp_d;
   logic [2:0]  resp_left_q, resp_left_d;
   logic [7:0]  err_q, err_d;
   logic        rx_fire, tx_fire;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign rx_fire = bus.rx_valid && bus.rx_ready;
   assign tx_fire = bus.tx_valid && bus.tx_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         halted_q    <= START_HALTED;
         is_write_q  <= 1'b0;
         bcnt_q      <= 2'd0;
         cyc_q       <= 32'd0;
         addr_q      <= 32'd0;
         data_q      <= 32'd0;
         resp_q      <= 32'd0;
         resp_left_q <= 3'd0;
         err_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         halted_q    <= halted_d;
         is_write_q  <= is_write_d;
         bcnt_q      <= bcnt_d;
         cyc_q       <= cyc_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         resp_q      <= resp_d;
         resp_left_q <= resp_left_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      halted_d    = halted_q;
      is_write_d  = is_write_q;
      bcnt_d      = bcnt_q;
      cyc_d       = cyc_q;
      addr_d      = addr_q;
      data_d      = data_q;
      resp_d      = resp_q;
      resp_left_d = resp_left_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            if (rx_fire) begin
               resp_d      = {BYTE_ACK, 24'd0};
               resp_left_d = 3'd1;
               bcnt_d      = 2'd0;
               cyc_d       = 32'd0;
               case (bus.rx_data)
                  OP_WRITE: begin is_write_d = 1'b1; state_d = S_ADDR; end
                  OP_READ:  begin is_write_d = 1'b0; state_d = S_ADDR; end
                  OP_HALT:  begin halted_d = 1'b1; state_d = S_SEND; end
                  OP_GO:    begin halted_d = 1'b0; state_d = S_SEND; end
                  default: begin
                     err_d   = sat_inc(err_q);
                     resp_d  = {BYTE_NAK, 24'd0};
                     state_d = S_SEND;
                  end
               endcase
            end
         end
         S_ADDR, S_DATA: begin
            // Idle counter restarts on every byte; the 4th byte also zeroes it for PAUSE_WAIT.
            if (rx_fire) begin
               cyc_d  = 32'd0;
               bcnt_d = bcnt_q + 2'd1;
               if (state_q == S_ADDR) addr_d = {addr_q[23:0], bus.rx_data};
               else                   data_d = {data_q[23:0], bus.rx_data};
               if (bcnt_q == 2'd3) begin
                  if (state_q == S_ADDR && is_write_q) state_d = S_DATA;
                  else                                 state_d = S_PAUSE_WAIT;
               end
            end else if (cyc_q == 32'(TIMEOUT - 1)) begin
               err_d   = sat_inc(err_q);
               state_d = S_IDLE;
            end else begin
               cyc_d = cyc_q + 32'd1;
            end
         end
         S_PAUSE_WAIT: begin
            if (cyc_q == 32'(PAUSE_SETTLE - 1)) begin
               cyc_d   = 32'd0;
               state_d = S_SETUP;
            end else begin
               cyc_d = cyc_q + 32'd1;
            end
         end
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            if (is_write_q) begin
               resp_d      = {BYTE_ACK, 24'd0};
               resp_left_d = 3'd1;
               state_d     = S_RELEASE;
            end else if (cyc_q == 32'(MEM_READ_LATENCY - 1)) begin
               resp_d      = bus.ext_data_out;
               resp_left_d = 3'd4;
               cyc_d       = 32'd0;
               state_d     = S_RELEASE;
            end else begin
               cyc_d = cyc_q + 32'd1;
            end
         end
         S_RELEASE: state_d = S_SEND;
         S_SEND: begin
            if (tx_fire) begin
               resp_d      = {resp_q[23:0], 8'd0};
               resp_left_d = resp_left_q - 3'd1;
               if (resp_left_q == 3'd1) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Processor stays paused for the whole memory takeover, whatever halted says.
   always_comb begin
      bus.rx_ready        = rst && (state_q inside {S_IDLE, S_ADDR, S_DATA});
      bus.tx_valid        = (state_q == S_SEND);
      bus.tx_data         = resp_q[31:24];
      bus.pause           = (state_q inside {S_PAUSE_WAIT, S_SETUP, S_ACCESS, S_RELEASE})
                            ? 1'b1 : halted_q;
      bus.ext_mem_control = (state_q inside {S_SETUP, S_ACCESS, S_RELEASE});
      bus.ext_write_mode  = (state_q == S_ACCESS && is_write_q)  ? MODE_WORD : MODE_NONE;
      bus.ext_read_mode   = (state_q == S_ACCESS && !is_write_q) ? MODE_WORD : MODE_NONE;
      bus.ext_address     = addr_q;
      bus.ext_data        = data_q;
      bus.busy            = (state_q != S_IDLE);
      bus.error_count     = err_q;
   end

endmodule

// File: tb/tb_host_memory_bridge.sv
// Randomized self-checking bench for host_memory_bridge with a word memory
// model on the external port and a command-level reference model.
module tb_host_memory_bridge;
   localparam int P   = 2;
   localparam int LAT = 2;
   localparam int TO  = 40;
   localparam bit SH  = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   pviol = 0;
   int   mviol = 0;

   logic [31:0] dmem [256];
   bit          dval [256];
   logic [31:0] ref_mem [256];
   bit          ref_val [256];
   bit          ref_halted;
   int          rd_cnt;

   host_memory_bridge_if bif();

   host_memory_bridge #(
      .PAUSE_SETTLE(P), .MEM_READ_LATENCY(LAT), .TIMEOUT(TO), .START_HALTED(SH),
      .MODE_NONE(3'd0), .MODE_WORD(3'd3)
   ) dut (
      .clk(clk), .rst(rst), .bus(bif)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [7:0] i);
      return {i, ~i, i ^ 8'h5A, 8'hC3};
   endfunction

   // Memory only presents data once the read mode has been held LAT cycles.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) dval[i] <= 1'b0;
         rd_cnt <= 0;
      end else begin
         rd_cnt <= (bif.ext_read_mode == 3'd3) ? rd_cnt + 1 : 0;
         if (bif.ext_mem_control && bif.ext_write_mode == 3'd3) begin
            dmem[bif.ext_address[7:0]] <= bif.ext_data;
            dval[bif.ext_address[7:0]] <= 1'b1;
         end
      end
   end

   assign bif.ext_data_out = (bif.ext_read_mode == 3'd3 && rd_cnt == LAT - 1)
      ? (dval[bif.ext_address[7:0]] ? dmem[bif.ext_address[7:0]] : pat(bif.ext_address[7:0]))
      : 32'h0BAD_F00D;

   always @(negedge clk) begin
      if (rst && bif.ext_mem_control && !bif.pause) pviol <= pviol + 1;
      if (rst && !bif.ext_mem_control && (bif.ext_write_mode != 3'd0 || bif.ext_read_mode != 3'd0))
         mviol <= mviol + 1;
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bif.rx_data = b; bif.rx_valid = 1'b1;
      while (bif.rx_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      if (bif.rx_ready !== 1'b1) begin
         n_chk++; $display("FAIL rx_accept timeout byte=%02h", b);
         bif.rx_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bif.rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
   endtask

   task automatic recv_byte(input int stall, output logic [7:0] b);
      int n = 0;
      b = 8'h00;
      @(negedge clk);
      while (bif.tx_valid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      if (bif.tx_valid !== 1'b1) begin
         n_chk++; $display("FAIL tx_wait timeout got=%b exp=1", bif.tx_valid);
         return;
      end
      b = bif.tx_data;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         n_chk++;
         if (bif.tx_valid !== 1'b1 || bif.tx_data !== b)
            $display("FAIL tx_hold got=%b/%02h exp=1/%02h", bif.tx_valid, bif.tx_data, b);
         else n_pass++;
      end
      bif.tx_ready = 1'b1;
      @(posedge clk); #1;
      bif.tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; bif.rx_valid = 1'b0; bif.rx_data = 8'h00; bif.tx_ready = 1'b0;
      for (int i = 0; i < 256; i++) ref_val[i] = 1'b0;
      ref_halted = SH;
      repeat (3) @(negedge clk);
      n_chk++; if (bif.pause !== SH) $display("FAIL rst_pause got=%b exp=%b", bif.pause, SH); else n_pass++;
      n_chk++; if (bif.ext_mem_control !== 1'b0) $display("FAIL rst_ctl got=%b exp=0", bif.ext_mem_control); else n_pass++;
      n_chk++; if (bif.tx_valid !== 1'b0) $display("FAIL rst_txv got=%b exp=0", bif.tx_valid); else n_pass++;
      n_chk++; if (bif.error_count !== 8'd0) $display("FAIL rst_err got=%0d exp=0", bif.error_count); else n_pass++;
      n_chk++; if (bif.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bif.busy); else n_pass++;
      n_chk++; if (bif.rx_ready !== 1'b0) $display("FAIL rst_rxrdy got=%b exp=0", bif.rx_ready); else n_pass++;
      n_chk++;
      if ({bif.ext_address, bif.ext_data, bif.ext_read_mode, bif.ext_write_mode} !== 70'd0)
         $display("FAIL rst_ext got=%h/%h/%0d/%0d exp=0", bif.ext_address, bif.ext_data,
                  bif.ext_read_mode, bif.ext_write_mode);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      int n = 0, ctl_n = 0, mc_n = 0, wr_n = 0, wr_bad = 0;
      logic [7:0] b;
      send_byte(8'h57); send_word(32'h0000_0010); send_word(32'hDEADBEEF);
      while (bif.tx_valid !== 1'b1 && n < 100) begin
         @(negedge clk); n++;
         if (bif.ext_mem_control === 1'b1) begin mc_n++; if (ctl_n == 0) ctl_n = n; end
         if (bif.ext_write_mode === 3'd3) begin
            wr_n++;
            if (bif.ext_mem_control !== 1'b1) wr_bad++;
         end
      end
      n_chk++; if (bif.ext_address !== 32'h10) $display("FAIL wr_addr got=%h exp=00000010", bif.ext_address); else n_pass++;
      n_chk++; if (bif.ext_data !== 32'hDEADBEEF) $display("FAIL wr_data got=%h exp=deadbeef", bif.ext_data); else n_pass++;
      n_chk++; if (wr_n != 1 || wr_bad != 0) $display("FAIL wr_mode_cycles got=%0d/%0d exp=1/0", wr_n, wr_bad); else n_pass++;
      n_chk++; if (ctl_n != P + 1) $display("FAIL wr_settle got=%0d exp=%0d", ctl_n - 1, P); else n_pass++;
      n_chk++; if (mc_n != 3) $display("FAIL wr_ctl_window got=%0d exp=3", mc_n); else n_pass++;
      n_chk++; if (n - 1 != P + 3) $display("FAIL wr_latency got=%0d exp=%0d", n - 1, P + 3); else n_pass++;
      recv_byte(0, b);
      n_chk++; if (b !== 8'h06) $display("FAIL wr_ack got=%02h exp=06", b); else n_pass++;
      ref_mem[8'h10] = 32'hDEADBEEF; ref_val[8'h10] = 1'b1;
   endtask

   task automatic test_go_read();
      int n = 0, ph = 0, rm = 0;
      logic [7:0]  b;
      logic [31:0] exp_w = 32'hDEADBEEF;
      send_byte(8'h47); recv_byte(0, b);
      ref_halted = 1'b0;
      n_chk++; if (b !== 8'h06) $display("FAIL go_ack got=%02h exp=06", b); else n_pass++;
      @(negedge clk);
      n_chk++; if (bif.pause !== 1'b0) $display("FAIL go_pause got=%b exp=0", bif.pause); else n_pass++;
      send_byte(8'h52); send_word(32'h0000_0010);
      while (bif.tx_valid !== 1'b1 && n < 100) begin
         @(negedge clk); n++;
         if (bif.pause === 1'b1) ph++;
         if (bif.ext_read_mode === 3'd3) rm++;
      end
      n_chk++; if (ph != P + LAT + 2) $display("FAIL rd_pause_cycles got=%0d exp=%0d", ph, P + LAT + 2); else n_pass++;
      n_chk++; if (rm != LAT) $display("FAIL rd_mode_cycles got=%0d exp=%0d", rm, LAT); else n_pass++;
      n_chk++; if (bif.pause !== 1'b0) $display("FAIL rd_pause_after got=%b exp=0", bif.pause); else n_pass++;
      for (int k = 3; k >= 0; k--) begin
         recv_byte(3, b);
         n_chk++; if (b !== exp_w[8*k +: 8]) $display("FAIL rd_byte%0d got=%02h exp=%02h", 3 - k, b, exp_w[8*k +: 8]); else n_pass++;
      end
   endtask

   task automatic test_timeout();
      logic [7:0] e0 = bif.error_count;
      logic [7:0] b;
      int txs = 0;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
      repeat (TO - 3) begin @(negedge clk); if (bif.tx_valid) txs++; end
      n_chk++; if (bif.busy !== 1'b1) $display("FAIL to_early got=%b exp=1", bif.busy); else n_pass++;
      repeat (10) begin @(negedge clk); if (bif.tx_valid) txs++; end
      n_chk++; if (bif.busy !== 1'b0) $display("FAIL to_idle got=%b exp=0", bif.busy); else n_pass++;
      n_chk++; if (bif.error_count !== e0 + 8'd1) $display("FAIL to_err got=%0d exp=%0d", bif.error_count, e0 + 8'd1); else n_pass++;
      n_chk++; if (txs != 0) $display("FAIL to_no_tx got=%0d exp=0", txs); else n_pass++;
      send_byte(8'h48); recv_byte(0, b);
      ref_halted = 1'b1;
      n_chk++; if (b !== 8'h06) $display("FAIL to_halt_ack got=%02h exp=06", b); else n_pass++;
   endtask

   task automatic test_nak_saturate();
      logic [7:0] e0 = bif.error_count;
      logic [7:0] b;
      int bad = 0;
      send_byte(8'h99); recv_byte(0, b);
      n_chk++; if (b !== 8'h15) $display("FAIL nak_byte got=%02h exp=15", b); else n_pass++;
      @(negedge clk);
      n_chk++; if (bif.error_count !== e0 + 8'd1) $display("FAIL nak_err got=%0d exp=%0d", bif.error_count, e0 + 8'd1); else n_pass++;
      for (int i = 1; i < 300; i++) begin
         send_byte(8'h99); recv_byte(0, b);
         if (b !== 8'h15) bad++;
      end
      @(negedge clk);
      n_chk++; if (bad != 0) $display("FAIL nak_repeat got=%0d exp=0", bad); else n_pass++;
      n_chk++; if (bif.error_count !== 8'd255) $display("FAIL nak_sat got=%0d exp=255", bif.error_count); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] a, d, r;
      logic [7:0]  b;
      int sel, st;
      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 3); st = $urandom_range(0, 2);
         a = $urandom(); a[7:0] = 8'($urandom_range(0, 7)); d = $urandom();
         case (sel)
            0: begin
               send_byte(8'h57); send_word(a); send_word(d); recv_byte(st, b);
               ref_mem[a[7:0]] = d; ref_val[a[7:0]] = 1'b1;
               n_chk++; if (b !== 8'h06) $display("FAIL rnd_w_ack got=%02h exp=06", b); else n_pass++;
               n_chk++;
               if (bif.ext_address !== a || bif.ext_data !== d)
                  $display("FAIL rnd_w_regs got=%h/%h exp=%h/%h", bif.ext_address, bif.ext_data, a, d);
               else n_pass++;
            end
            1: begin
               r = ref_val[a[7:0]] ? ref_mem[a[7:0]] : pat(a[7:0]);
               send_byte(8'h52); send_word(a);
               for (int k = 3; k >= 0; k--) begin
                  recv_byte(st, b);
                  n_chk++; if (b !== r[8*k +: 8]) $display("FAIL rnd_r_byte got=%02h exp=%02h", b, r[8*k +: 8]); else n_pass++;
               end
            end
            default: begin
               send_byte(sel == 2 ? 8'h48 : 8'h47); recv_byte(st, b);
               ref_halted = (sel == 2);
               n_chk++; if (b !== 8'h06) $display("FAIL rnd_hg_ack got=%02h exp=06", b); else n_pass++;
            end
         endcase
         @(negedge clk);
         n_chk++;
         if (bif.pause !== ref_halted || bif.busy !== 1'b0)
            $display("FAIL rnd_idle got=%b/%b exp=%b/0", bif.pause, bif.busy, ref_halted);
         else n_pass++;
      end
      n_chk++; if (pviol != 0) $display("FAIL ctl_without_pause got=%0d exp=0", pviol); else n_pass++;
      n_chk++; if (mviol != 0) $display("FAIL mode_without_ctl got=%0d exp=0", mviol); else n_pass++;
   endtask

   task automatic test_reset_mid_access();
      int n = 0, txs = 0;
      send_byte(8'h57); send_word(32'h0000_0020); send_word(32'h1234_5678);
      while (bif.ext_write_mode !== 3'd3 && n < 50) begin @(negedge clk); n++; end
      n_chk++; if (bif.ext_write_mode !== 3'd3) $display("FAIL mid_access_reach got=%0d exp=3", bif.ext_write_mode); else n_pass++;
      rst = 1'b0; #1;
      n_chk++; if (bif.ext_mem_control !== 1'b0) $display("FAIL mid_ctl got=%b exp=0", bif.ext_mem_control); else n_pass++;
      n_chk++; if (bif.ext_write_mode !== 3'd0) $display("FAIL mid_wmode got=%0d exp=0", bif.ext_write_mode); else n_pass++;
      n_chk++; if (bif.pause !== SH) $display("FAIL mid_pause got=%b exp=%b", bif.pause, SH); else n_pass++;
      n_chk++; if (bif.busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", bif.busy); else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) begin @(negedge clk); if (bif.tx_valid) txs++; end
      n_chk++; if (txs != 0) $display("FAIL mid_no_ack got=%0d exp=0", txs); else n_pass++;
      n_chk++; if (bif.busy !== 1'b0) $display("FAIL mid_idle got=%b exp=0", bif.busy); else n_pass++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write();
      test_go_read();
      test_timeout();
      test_nak_saturate();
      test_random();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
